fifo_sr_reader: RTL

Read-side engine for the shared-storage multi-flux FIFO. Watches the per-flux empty flags, picks one non-empty flux per cycle by round-robin, issues the one-hot read strobe, captures the tagged word and routes it into a small per-flux output buffer. Each output buffer drives an independent valid/ready stream toward that flux's consumer. It sits between the FIFO read port and the FLUX downstream actors, so a stalled consumer never blocks the other fluxes.

---
 rtl/fifo_sr_pkg.sv | 45 ++++
 rtl/flux_out_buf.sv | 53 +++++
 rtl/fifo_sr_reader.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_sr_pkg.sv
// Shared types and helpers for the multi-flux FIFO read engine:
// round-robin search, one-hot decode and tag-field width.
package fifo_sr_pkg;

   localparam int MAX_FLUX = 32;

   typedef struct packed {
      logic        valid;
      logic [31:0] idx;
   } grant_t;

   function automatic int tag_width(input int flux);
      return (flux > 1) ? $clog2(flux) : 1;
   endfunction

   function automatic int onehot2bin(input logic [MAX_FLUX-1:0] oh);
      int b;
      b = 0;
      for (int i = 0; i < MAX_FLUX; i++) begin
         if (oh[i]) b = i;
      end
      return b;
   endfunction

   // Searches rr+1, rr+2, ... modulo n; walking the offsets downward lets
   // the nearest requester overwrite the farther ones.
   function automatic grant_t rr_next(input logic [MAX_FLUX-1:0] req,
                                      input int rr, input int n);
      grant_t g;
      int     k;
      g.valid = 1'b0;
      g.idx   = '0;
      for (int i = MAX_FLUX; i >= 1; i--) begin
         if (i <= n) begin
            k = (rr + i) % n;
            if (req[k]) begin
               g.valid = 1'b1;
               g.idx   = 32'(k);
            end
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/flux_out_buf.sv
// Small circular buffer feeding one flux's valid/ready consumer; the
// occupancy output is what the read engine uses for credit.
module flux_out_buf #(
   parameter  int DATA_WIDTH = 8,
   parameter  int BUF_DEPTH  = 2,
   localparam int OCC_W      = $clog2(BUF_DEPTH + 1),
   localparam int PTR_W      = $clog2(BUF_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   input  logic                  ready,
   output logic [OCC_W-1:0]      occ
);

   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  pop;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign valid = (occ != '0);
   assign pop   = valid && ready;
   // Head is forced to zero when empty so the port reads 0 out of reset.
   assign data  = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fifo_sr_reader.sv
// Read-side engine of the shared-storage multi-flux FIFO: credit-gated
// round-robin read issue, tagged capture and per-flux output buffering.
module fifo_sr_reader
   import fifo_sr_pkg::*;
#(
   parameter  int DATA_WIDTH   = 8,
   parameter  int FLUX         = 2,
   parameter  int READ_LATENCY = 0,
   parameter  int BUF_DEPTH    = 2,
   localparam int TAG_WIDTH    = tag_width(FLUX)
) (
   input  logic                            clk,
   input  logic                            rst,
   output logic [FLUX-1:0]                 fifo_read,
   input  logic [FLUX-1:0]                 fifo_empty,
   input  logic [TAG_WIDTH+DATA_WIDTH-1:0] fifo_dout,
   output logic [FLUX-1:0]                 m_valid,
   output logic [FLUX*DATA_WIDTH-1:0]      m_data,
   input  logic [FLUX-1:0]                 m_ready,
   output logic                            tag_err
);

   localparam int OCC_W = $clog2(BUF_DEPTH + 1);

   logic [OCC_W-1:0]      occ [FLUX];
   logic [FLUX-1:0]       infl;
   logic [FLUX-1:0]       eligible;
   logic [FLUX-1:0]       push;
   logic [TAG_WIDTH-1:0]  rr;
   logic [TAG_WIDTH-1:0]  gnt_idx;
   logic                  gnt_vld;
   grant_t                gnt;
   logic                  cap_vld;
   logic [TAG_WIDTH-1:0]  cap_flux;
   logic [TAG_WIDTH-1:0]  dout_tag;
   logic [DATA_WIDTH-1:0] dout_data;

   assign {dout_tag, dout_data} = fifo_dout;

   // Stage p0: credit check and arbitration on registered occupancy only,
   // so a pop never reaches fifo_read in the same cycle.
   always_comb begin
      for (int f = 0; f < FLUX; f++) begin
         eligible[f] = !fifo_empty[f] && ((int'(occ[f]) + int'(infl[f])) < BUF_DEPTH);
      end
      gnt       = rr_next(MAX_FLUX'(eligible), int'(rr), FLUX);
      gnt_vld   = gnt.valid && !rst;
      gnt_idx   = TAG_WIDTH'(gnt.idx);
      fifo_read = '0;
      if (gnt_vld) fifo_read[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)          rr <= TAG_WIDTH'(FLUX - 1);
      else if (gnt_vld) rr <= gnt_idx;
   end

   generate
      if (READ_LATENCY == 0) begin : g_lat0
         assign cap_vld  = gnt_vld;
         assign cap_flux = gnt_idx;
         assign infl     = '0;
      end else begin : g_lat1
         logic                 vld_p1;
         logic [TAG_WIDTH-1:0] flux_p1;

         // Stage p1: the word granted last cycle arrives now.
         always_ff @(posedge clk) begin
            if (rst) vld_p1 <= 1'b0;
            else     vld_p1 <= gnt_vld;
            flux_p1 <= gnt_idx;
         end

         assign cap_vld  = vld_p1 && !rst;
         assign cap_flux = flux_p1;

         always_comb begin
            for (int f = 0; f < FLUX; f++) begin
               infl[f] = vld_p1 && (flux_p1 == TAG_WIDTH'(f));
            end
         end
      end
   endgenerate

   // Capture: the word goes to the flux we asked for even when its tag disagrees.
   always_comb begin
      push = '0;
      if (cap_vld) push[cap_flux] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)                                tag_err <= 1'b0;
      else if (cap_vld && dout_tag != cap_flux) tag_err <= 1'b1;
   end

   generate
      for (genvar f = 0; f < FLUX; f++) begin : g_buf
         flux_out_buf #(
            .DATA_WIDTH (DATA_WIDTH),
            .BUF_DEPTH  (BUF_DEPTH)
         ) u_buf (
            .clk       (clk),
            .rst       (rst),
            .push      (push[f]),
            .push_data (dout_data),
            .valid     (m_valid[f]),
            .data      (m_data[f*DATA_WIDTH +: DATA_WIDTH]),
            .ready     (m_ready[f]),
            .occ       (occ[f])
         );
      end
   endgenerate

endmodule
